// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multi-cycle RISC core: sequences fetch, decode,
// execute, memory and writeback, with a req/ready memory handshake and a timeout.
module multicycle_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             reg_we,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             instr_done,
   output logic             illegal,
   output logic             bus_err,
   output logic [CNT_W-1:0] retire_cnt
);

   localparam int WAIT_W = $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_ADDR   = 4'd2;
   localparam logic [3:0] S_MEM    = 4'd3;
   localparam logic [3:0] S_WBL    = 4'd4;
   localparam logic [3:0] S_EXEC   = 4'd5;
   localparam logic [3:0] S_WBR    = 4'd6;
   localparam logic [3:0] S_BRANCH = 4'd7;
   localparam logic [3:0] S_JUMP   = 4'd8;

   localparam logic [3:0] OP_LD  = 4'b0000;
   localparam logic [3:0] OP_ST  = 4'b0001;
   localparam logic [3:0] OP_BEQ = 4'b1011;
   localparam logic [3:0] OP_BNE = 4'b1100;
   localparam logic [3:0] OP_JMP = 4'b1101;

   logic [3:0]        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

   logic is_rtype;
   logic mem_wait_last;

   assign is_rtype      = (opcode >= 4'b0010) && (opcode <= 4'b1001);
   assign mem_wait_last = !mem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_sel    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_src     = 2'b00;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (run) begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_DECODE;
               end else if (mem_wait_last) begin
                  bus_err = 1'b1;
               end
            end
         end
         S_DECODE: begin
            if (opcode == OP_LD || opcode == OP_ST) state_d = S_ADDR;
            else if (is_rtype)                      state_d = S_EXEC;
            else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BRANCH;
            else if (opcode == OP_JMP)              state_d = S_JUMP;
            else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_ADDR: begin
            alu_op  = 2'b10;
            alu_src = 1'b1;
            state_d = S_MEM;
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_sel = 1'b1;
            mem_we  = (opcode == OP_ST);
            alu_op  = 2'b10;
            alu_src = 1'b1;
            if (mem_ready) begin
               if (opcode == OP_ST) begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WBL;
               end
            end else if (mem_wait_last) begin
               bus_err = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WBL: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXEC: begin
            state_d = S_WBR;
         end
         S_WBR: begin
            reg_we     = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_op     = 2'b01;
            instr_done = 1'b1;
            if ((opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero)) begin
               pc_we  = 1'b1;
               pc_src = 2'b01;
            end
            state_d = S_FETCH;
         end
         S_JUMP: begin
            pc_we      = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // A fetch timeout stays in FETCH, so the count must also clear on bus_err.
      if (state_d != state_q || bus_err) wait_d = '0;
      else if (mem_req && !mem_ready)    wait_d = wait_q + 1'b1;
      else                               wait_d = wait_q;

      retire_cnt_d = instr_done ? retire_cnt_q + 1'b1 : retire_cnt_q;

      if (rst) begin
         mem_req    = 1'b0;
         mem_we     = 1'b0;
         mem_sel    = 1'b0;
         ir_we      = 1'b0;
         pc_we      = 1'b0;
         pc_src     = 2'b00;
         alu_op     = 2'b00;
         alu_src    = 1'b0;
         reg_we     = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
         bus_err    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         wait_q       <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: each instruction is expanded into its expected
// per-cycle control words from the instruction-level rules, then replayed.
module tb_multicycle_ctrl;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   logic             clk, rst, run, zero, mem_ready;
   logic [3:0]       opcode;
   logic             mem_req, mem_we, mem_sel, ir_we, pc_we, alu_src;
   logic             reg_we, reg_dst, mem_to_reg, instr_done, illegal, bus_err;
   logic [1:0]       pc_src, alu_op;
   logic [CNT_W-1:0] retire_cnt;

   multicycle_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_sel(mem_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_op(alu_op), .alu_src(alu_src), .reg_we(reg_we), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal),
      .bus_err(bus_err), .retire_cnt(retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word: {req,we,sel,ir,pcwe,pc_src[2],alu_op[2],asrc,rwe,rdst,m2r,done,ill,berr}
   localparam int W = 16;
   logic [W-1:0] obs;
   assign obs = {mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, alu_op, alu_src,
                 reg_we, reg_dst, mem_to_reg, instr_done, illegal, bus_err};

   logic [W-1:0] exp_q[$];
   logic [1:0]   stim_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int exp_cnt  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [W-1:0] cw(input logic req, we, sel, ir, pcwe,
                                       input logic [1:0] psrc, aop,
                                       input logic asrc, rwe, rdst, m2r, done, ill, berr);
      return {req, we, sel, ir, pcwe, psrc, aop, asrc, rwe, rdst, m2r, done, ill, berr};
   endfunction

   task automatic push(input logic [W-1:0] e, input logic r, input logic rdy);
      exp_q.push_back(e);
      stim_q.push_back({r, rdy});
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Instruction-level model: fw/mw are cycles of mem_ready=0 before the fetch/data
   // access is answered; a run of TIMEOUT unanswered cycles aborts that access.
   task automatic model_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
      int rem;
      logic [W-1:0] mw_word;
      rem = fw;
      while (rem >= TIMEOUT) begin
         for (int i = 0; i < TIMEOUT - 1; i++) push(cw(1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), 1, 0);
         push(cw(1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,1), 1, 0);
         rem -= TIMEOUT;
      end
      for (int i = 0; i < rem; i++) push(cw(1,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,0), 1, 0);
      push(cw(1,0,0,1,1,2'b00,2'b00,0,0,0,0,0,0,0), 1, 1);
      if (op == 4'hA || op == 4'hE || op == 4'hF) begin
         push(cw(0,0,0,0,0,2'b00,2'b00,0,0,0,0,0,1,0), rnd(), rnd());
         return;
      end
      push('0, rnd(), rnd());
      if (op <= 4'd1) begin
         push(cw(0,0,0,0,0,2'b00,2'b10,1,0,0,0,0,0,0), rnd(), rnd());
         mw_word = cw(1, op == 4'd1, 1, 0, 0, 2'b00, 2'b10, 1, 0, 0, 0, 0, 0, 0);
         if (mw >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT - 1; i++) push(mw_word, rnd(), 0);
            push(mw_word | cw(0,0,0,0,0,2'b00,2'b00,0,0,0,0,0,0,1), rnd(), 0);
            return;
         end
         for (int i = 0; i < mw; i++) push(mw_word, rnd(), 0);
         if (op == 4'd1) begin
            push(mw_word | cw(0,0,0,0,0,2'b00,2'b00,0,0,0,0,1,0,0), rnd(), 1);
         end else begin
            push(mw_word, rnd(), 1);
            push(cw(0,0,0,0,0,2'b00,2'b00,0,1,0,1,1,0,0), rnd(), rnd());
         end
      end else if (op <= 4'd9) begin
         push('0, rnd(), rnd());
         push(cw(0,0,0,0,0,2'b00,2'b00,0,1,1,0,1,0,0), rnd(), rnd());
      end else if (op == 4'hB || op == 4'hC) begin
         if ((op == 4'hB) == z)
            push(cw(0,0,0,0,1,2'b01,2'b01,0,0,0,0,1,0,0), rnd(), rnd());
         else
            push(cw(0,0,0,0,0,2'b00,2'b01,0,0,0,0,1,0,0), rnd(), rnd());
      end else begin
         push(cw(0,0,0,0,1,2'b10,2'b00,0,0,0,0,1,0,0), rnd(), rnd());
      end
   endtask

   // Replays up to n queued cycles (n < 0 drains everything).
   task automatic drain(input string tag, input int n);
      logic [W-1:0] e;
      logic [1:0]   s;
      int k = 0;
      while (exp_q.size() > 0 && (n < 0 || k < n)) begin
         e = exp_q.pop_front();
         s = stim_q.pop_front();
         run       = s[1];
         mem_ready = s[0];
         @(negedge clk);
         check_eq({tag, " ctl"}, 32'(obs), 32'(e));
         check_eq({tag, " retire"}, 32'(retire_cnt), 32'(exp_cnt));
         if (e[2]) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
         @(posedge clk);
         #1;
         k++;
      end
   endtask

   task automatic do_instr(input string tag, input logic [3:0] op, input int fw,
                           input int mw, input logic z);
      opcode = op;
      zero   = z;
      model_instr(op, fw, mw, z);
      drain(tag, -1);
   endtask

   task automatic reset_cycles(input string tag, input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         run       = 1'b1;
         mem_ready = rnd();
         @(negedge clk);
         check_eq({tag, " ctl"}, 32'(obs), 32'd0);
         @(posedge clk);
         #1;
         check_eq({tag, " retire"}, 32'(retire_cnt), 32'd0);
      end
      rst     = 1'b0;
      exp_cnt = 0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
      @(posedge clk);
      #1;
      reset_cycles("reset", 3);

      do_instr("add",        4'h2, 0, 0, 1'b0);
      do_instr("ld_wait2",   4'h0, 0, 2, 1'b0);
      do_instr("beq_taken",  4'hB, 0, 0, 1'b1);
      do_instr("bne_nottkn", 4'hC, 0, 0, 1'b1);
      do_instr("illegal",    4'hF, 0, 0, 1'b0);
      do_instr("fetch_to",   4'h5, TIMEOUT, 0, 1'b0);
      do_instr("fetch_last", 4'h9, TIMEOUT - 1, 0, 1'b0);
      do_instr("st_wait",    4'h1, 1, TIMEOUT - 1, 1'b0);
      do_instr("st_to",      4'h1, 0, TIMEOUT, 1'b0);
      do_instr("jmp",        4'hD, 0, 0, 1'b0);

      for (int i = 0; i < 3; i++) push('0, 0, rnd());
      drain("idle", -1);

      opcode = 4'h0;
      model_instr(4'h0, 0, 1, 1'b0);
      drain("ld_abort", 3);
      exp_q.delete();
      stim_q.delete();
      reset_cycles("mid_reset", 2);

      for (int i = 0; i < 200; i++) begin
         logic [3:0] op;
         int fw, mw;
         op = 4'($urandom_range(0, 15));
         fw = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT, 2 * TIMEOUT) : $urandom_range(0, 2);
         mw = ($urandom_range(0, 7) == 0) ? TIMEOUT : $urandom_range(0, TIMEOUT - 1);
         if ($urandom_range(0, 5) == 0) begin
            for (int j = 0; j < $urandom_range(1, 3); j++) push('0, 0, rnd());
            drain("rnd_idle", -1);
         end
         do_instr("rnd", op, fw, mw, rnd());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the 16-bit multi-cycle RISC core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives alu_op to the ALU control decoder and enables for the PC, IR, register file and the shared instruction/data memory port.
- Handles memory wait states through a req/ready handshake with a timeout.

Parameters:
TIMEOUT, 16, cycles mem_req may stay unanswered before the access is aborted (min 2)
CNT_W, 16, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
run  input  1  allow new instruction fetches
opcode  input  4  IR[15:12], valid from DECODE onward
zero  input  1  ALU zero flag (combinational from ALU)
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
mem_we  output  1  memory write (store)
mem_sel  output  1  0 = address from PC, 1 = address from ALU result
ir_we  output  1  load instruction register
pc_we  output  1  update PC
pc_src  output  2  00 PC+2, 01 branch target, 10 jump target
alu_op  output  2  10 add (address), 01 subtract (compare), 00 decode by opcode
alu_src  output  1  0 = register B, 1 = sign-extended immediate
reg_we  output  1  register file write
reg_dst  output  1  0 = rt destination, 1 = rd destination
mem_to_reg  output  1  writeback source: 1 = memory data, 0 = ALU
instr_done  output  1  one-cycle pulse, instruction retired
illegal  output  1  one-cycle pulse, undefined opcode
bus_err  output  1  one-cycle pulse, memory timeout
retire_cnt  output  CNT_W  retired instructions, wraps at 2^CNT_W

Behaviour:
- State, wait counter and retire_cnt are registered. All other outputs are combinational from state, opcode, zero and mem_ready.
- Any output not listed for a state is 0.
- Reset:
  - rst high forces state FETCH, wait counter 0, retire_cnt 0.
  - All outputs are 0 while rst is high, including mem_req.
  - rst mid-instruction abandons it; no pulses or writes occur.
- Opcode map: 0000 LD, 0001 ST, 0010-1001 R-type, 1011 BEQ, 1100 BNE, 1101 JMP. 1010, 1110 and 1111 are illegal.
- FETCH:
  - run=0: idle, no outputs.
  - run=1: mem_req=1, mem_sel=0.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=00, next state DECODE.
- DECODE:
  - One cycle, no outputs.
  - Next state: LD/ST -> ADDR; R-type -> EXEC; BEQ/BNE -> BRANCH; JMP -> JUMP.
  - Illegal opcode: illegal=1, next FETCH, not retired.
- ADDR: alu_op=10, alu_src=1; next MEM.
- MEM:
  - mem_req=1, mem_sel=1, mem_we=1 for ST only, alu_op=10, alu_src=1.
  - On mem_ready: LD -> WBL; ST -> FETCH with instr_done=1.
- WBL: reg_we=1, mem_to_reg=1, reg_dst=0, instr_done=1; next FETCH.
- EXEC: alu_op=00, alu_src=0; next WBR.
- WBR: alu_op=00, reg_we=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
- BRANCH:
  - alu_op=01, alu_src=0.
  - pc_we=1, pc_src=01 iff (BEQ and zero) or (BNE and !zero).
  - instr_done=1; next FETCH.
- JUMP: pc_we=1, pc_src=10, instr_done=1; next FETCH.
- Latency with zero wait states:
  - R-type: 4 cycles.
  - LD: 5 cycles. ST: 4 cycles.
  - BEQ/BNE/JMP: 3 cycles.
  - Each mem_ready-low cycle adds one cycle.
- Timeout:
  - The wait counter increments on each FETCH/MEM cycle with mem_req=1 and mem_ready=0. It clears on state change.
  - The counter reaching TIMEOUT-1 with mem_ready still 0 gives bus_err=1 that cycle and next state FETCH.
  - No ir_we, pc_we or reg_we occurs on a timeout, so a fetch retries the same PC. The aborted instruction is not retired.
  - mem_ready in the same cycle as the last count completes normally; there is no bus_err.
- run deasserted mid-instruction: the instruction completes; the FSM idles in FETCH.
- retire_cnt increments by 1 on every instr_done cycle and wraps to 0 from all-ones.
- mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset with rst=1 for 3 cycles, run=1 -> all outputs 0 and retire_cnt=0. First mem_req=1 appears the cycle after rst falls.
- ADD (0010) with mem_ready tied 1 -> ir_we/pc_we in cycle 0, alu_op=00 in cycles 2-3, reg_we=reg_dst=1 plus instr_done in cycle 3, retire_cnt=1.
- LD (0000) with data mem_ready delayed 2 cycles -> MEM holds mem_sel=1, mem_we=0 for 3 cycles. WBL asserts reg_we=1, mem_to_reg=1. Total 7 cycles.
- BEQ with zero=1, then BNE with zero=1 -> first gives pc_we=1, pc_src=01. Second gives pc_we=0. Both pulse instr_done.
- Opcode 1111 -> illegal pulse in DECODE, no reg_we, retire_cnt unchanged, FETCH next cycle.
- TIMEOUT=4, fetch mem_ready held 0 -> bus_err in the 4th request cycle, no ir_we/pc_we, FETCH reissues. Repeat with mem_ready in the 4th cycle -> normal fetch, no bus_err.
